fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It drives a request/acknowledge instruction memory
// port, presents fetched words in an IF/ID output register, parks one word
// when the downstream stage stalls, and handles branch redirects from execute,
// including a redirect that arrives while a memory request is still in flight.
//
// Memory handshake: imem_req/imem_addr are registered and stay stable while a
// request is outstanding. The request completes in the first cycle in which
// imem_ack is sampled high while imem_req=1 (which may be the cycle imem_req
// rises). imem_ack is ignored while imem_req=0.
//
// Ports
//   clk         in   1   clock, rising edge
//   res         in   1   asynchronous active-high reset
//   stall       in   1   downstream hold; IF/ID register must not advance
//   br_taken    in   1   one-cycle redirect request (wins over stall)
//   br_target   in  32   redirect address, bits [1:0] ignored
//   imem_req    out  1   instruction memory request
//   imem_addr   out 32   instruction memory word address
//   imem_ack    in   1   memory completion
//   imem_rdata  in  32   instruction word, valid with imem_ack
//   valid_out   out  1   pc_out/order_out hold a real instruction
//   pc_out      out 32   address of the presented instruction
//   order_out   out 32   presented instruction word (0 when not valid)
//   dbg_state_o out  2   FSM state: 0 IDLE, 1 BUSY, 2 PEND, 3 DRAIN
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] order_out,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_PEND  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] pend_word_q, pend_word_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] order_q, order_d;
    logic        req_q, req_d;

    logic [31:0] br_target_w;
    logic [31:0] fetch_addr_inc;
    logic        slot_free;
    logic        ack_seen;

    assign br_target_w    = {br_target[31:2], 2'b00};
    assign fetch_addr_inc = fetch_addr_q + 32'd4;   // wraps modulo 2^32
    assign slot_free      = !valid_q || !stall;
    assign ack_seen       = req_q && imem_ack;      // stray acks are ignored

    // -------------------------------------------------------------------------
    // Next-state and output-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        tgt_d        = tgt_q;
        pend_pc_d    = pend_pc_q;
        pend_word_d  = pend_word_q;
        valid_d      = valid_q;
        pc_d         = pc_q;
        order_d      = order_q;

        // Slot default: hold while stalled, otherwise become a bubble unless
        // one of the cases below loads a new instruction.
        if (!stall) begin
            valid_d = 1'b0;
            pc_d    = 32'h0;
            order_d = 32'h0;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_BUSY;
                if (br_taken) begin
                    fetch_addr_d = br_target_w;
                end
            end

            S_BUSY: begin
                if (br_taken) begin
                    if (ack_seen) begin
                        // Returned word belongs to the wrong path: drop it.
                        fetch_addr_d = br_target_w;
                    end else begin
                        // Request still in flight; wait it out before redirecting.
                        tgt_d   = br_target_w;
                        state_d = S_DRAIN;
                    end
                end else if (ack_seen) begin
                    fetch_addr_d = fetch_addr_inc;
                    if (slot_free) begin
                        valid_d = 1'b1;
                        pc_d    = fetch_addr_q;
                        order_d = imem_rdata;
                    end else begin
                        pend_pc_d   = fetch_addr_q;
                        pend_word_d = imem_rdata;
                        state_d     = S_PEND;
                    end
                end
            end

            S_PEND: begin
                if (br_taken) begin
                    pend_pc_d    = 32'h0;
                    pend_word_d  = 32'h0;
                    fetch_addr_d = br_target_w;
                    state_d      = S_BUSY;
                end else if (!stall) begin
                    valid_d     = 1'b1;
                    pc_d        = pend_pc_q;
                    order_d     = pend_word_q;
                    pend_pc_d   = 32'h0;
                    pend_word_d = 32'h0;
                    state_d     = S_BUSY;
                end
            end

            S_DRAIN: begin
                if (br_taken) begin
                    tgt_d = br_target_w;   // latest redirect wins
                end
                if (ack_seen) begin
                    fetch_addr_d = br_taken ? br_target_w : tgt_q;
                    state_d      = S_BUSY;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect always clears the IF/ID slot, even under stall.
        if (br_taken) begin
            valid_d = 1'b0;
            pc_d    = 32'h0;
            order_d = 32'h0;
        end

        req_d = (state_d == S_BUSY) || (state_d == S_DRAIN);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_PC_W;
            tgt_q        <= 32'h0;
            pend_pc_q    <= 32'h0;
            pend_word_q  <= 32'h0;
            valid_q      <= 1'b0;
            pc_q         <= 32'h0;
            order_q      <= 32'h0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            tgt_q        <= tgt_d;
            pend_pc_q    <= pend_pc_d;
            pend_word_q  <= pend_word_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            order_q      <= order_d;
            req_q        <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_addr_q;
    assign valid_out   = valid_q;
    assign pc_out      = pc_q;
    assign order_out   = order_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. dut_a (RESET_PC=0) is driven by a latency-configurable
// memory responder; every accepted fetch is pushed to exp_q and popped when the
// fetch stage is expected to present it. dut_b (RESET_PC=FFFF_FFFC) runs with a
// zero-wait memory to check address wrap from the reset PC.
// Inputs are driven at the falling edge; outputs are checked at the falling
// edge, half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic res;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut_a ----------------
    logic        stall, br_taken;
    logic [31:0] br_target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        valid_out;
    logic [31:0] pc_out, order_out;
    logic [1:0]  dbg_state;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .res(res), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid_out(valid_out),
        .pc_out(pc_out), .order_out(order_out), .dbg_state_o(dbg_state)
    );

    // ---------------- dut_b (wrap check) ----------------
    logic        req_b, ack_b, valid_b;
    logic [31:0] addr_b, rdata_b, pc_b, order_b;
    logic [1:0]  dbg_state_b;

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .res(res), .stall(1'b0), .br_taken(1'b0),
        .br_target(32'h0), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack_b), .imem_rdata(rdata_b), .valid_out(valid_b),
        .pc_out(pc_b), .order_out(order_b), .dbg_state_o(dbg_state_b)
    );

    // Memory image: word at address a is ((a>>2)+1)*0x11 -> 0x11, 0x22, 0x33 ...
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    assign ack_b   = req_b;
    assign rdata_b = mem_word(addr_b);

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];          // {pc, word} of accepted, not yet presented fetches
    logic [31:0] exp_fetch;         // address the next request must carry
    logic [31:0] drain_tgt;
    logic        drain;             // redirect waiting for the in-flight request
    logic        started;           // first edge after reset has happened
    logic        exp_valid;
    logic [31:0] exp_pc, exp_word;
    int          lat;
    int          wait_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fetch = 32'h0;
        drain_tgt = 32'h0;
        drain     = 1'b0;
        started   = 1'b0;
        exp_valid = 1'b0;
        exp_pc    = 32'h0;
        exp_word  = 32'h0;
        wait_cnt  = 0;
    endtask

    task automatic check_outputs();
        logic       exp_req;
        logic [1:0] exp_st;
        exp_req = started && (exp_q.size() == 0);
        if (!started)               exp_st = ST_IDLE;
        else if (exp_q.size() != 0) exp_st = ST_PEND;
        else if (drain)             exp_st = ST_DRAIN;
        else                        exp_st = ST_BUSY;
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check_eq("imem_addr", imem_addr, exp_fetch);
        check_eq("state", {30'b0, dbg_state}, {30'b0, exp_st});
        check_eq("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
        check_eq("pc_out", pc_out, exp_pc);
        check_eq("order_out", order_out, exp_word);
    endtask

    // One cycle: check, drive inputs and memory response, update model, clock.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt);
        logic        ack_v;
        logic        free;
        logic [63:0] e;
        check_outputs();
        stall     = st;
        br_taken  = br;
        br_target = tgt;
        ack_v      = imem_req && (wait_cnt >= lat);
        imem_ack   = ack_v;
        imem_rdata = ack_v ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        if (imem_req && !ack_v) wait_cnt++;
        else                    wait_cnt = 0;

        if (!started) begin
            started = 1'b1;
            if (br) exp_fetch = {tgt[31:2], 2'b00};
        end else if (br) begin
            exp_q.delete();
            exp_valid = 1'b0;
            exp_pc    = 32'h0;
            exp_word  = 32'h0;
            if (imem_req && !ack_v) begin
                drain     = 1'b1;
                drain_tgt = {tgt[31:2], 2'b00};
            end else begin
                drain     = 1'b0;
                exp_fetch = {tgt[31:2], 2'b00};
            end
        end else begin
            free = !exp_valid || !st;
            if (ack_v) begin
                if (drain) begin
                    drain     = 1'b0;
                    exp_fetch = drain_tgt;
                end else begin
                    exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
            if (free) begin
                if (exp_q.size() != 0) begin
                    e         = exp_q.pop_front();
                    exp_valid = 1'b1;
                    exp_pc    = e[63:32];
                    exp_word  = e[31:0];
                end else begin
                    exp_valid = 1'b0;
                    exp_pc    = 32'h0;
                    exp_word  = 32'h0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        res        = 1'b1;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        imem_ack   = 1'b1;          // stray ack during reset must be ignored
        imem_rdata = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        res      = 1'b0;
        imem_ack = 1'b0;
        model_reset();
    endtask

    // Reset asserted between edges while a request is outstanding.
    task automatic reset_mid();
        imem_ack   = imem_req;
        imem_rdata = 32'hCAFE_F00D;
        #2;
        res = 1'b1;
        #1;
        check_eq("rst_mid_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_mid_valid", {31'b0, valid_out}, 32'h0);
        check_eq("rst_mid_pc", pc_out, 32'h0);
        check_eq("rst_mid_order", order_out, 32'h0);
        check_eq("rst_mid_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        res      = 1'b0;
        imem_ack = 1'b0;
        model_reset();
    endtask

    initial begin
        res        = 1'b1;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        lat        = 0;
        model_reset();
        @(negedge clk);

        // Zero-wait stream 0x0, 0x4, 0x8 ..., plus RESET_PC wrap on dut_b.
        apply_reset();
        check_eq("b_rst_req", {31'b0, req_b}, 32'h0);
        check_eq("b_rst_valid", {31'b0, valid_b}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_eq("b_req1", {31'b0, req_b}, 32'h1);
        check_eq("b_addr1", addr_b, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check_eq("b_addr2", addr_b, 32'h0000_0000);
        check_eq("b_valid2", {31'b0, valid_b}, 32'h1);
        check_eq("b_pc2", pc_b, 32'hFFFF_FFFC);
        check_eq("b_order2", order_b, 32'h4000_0000);
        step(1'b0, 1'b0, 32'h0);
        check_eq("b_pc3", pc_b, 32'h0);
        check_eq("b_order3", order_b, 32'h11);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Two-cycle memory latency: bubbles between instructions.
        apply_reset();
        lat = 2;
        repeat (12) step(1'b0, 1'b0, 32'h0);

        // Stall for 3 cycles once 0x4 is presented: 0x8 parks in PEND.
        apply_reset();
        lat = 0;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        check_eq("stall_pc4", pc_out, 32'h4);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);

        // Redirect to 0x100 while request to 0x8 is outstanding (low bits ignored),
        // then two redirects while draining: the later one wins.
        apply_reset();
        lat = 2;
        repeat (7) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0103);
        repeat (8) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0300);
        step(1'b0, 1'b1, 32'h0000_0400);
        repeat (8) step(1'b0, 1'b0, 32'h0);

        // Redirect with stall=1 while in PEND: pending dropped, output cleared.
        apply_reset();
        lat = 0;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0080);
        step(1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Reset pulsed mid-request, then restart from RESET_PC.
        lat = 2;
        repeat (4) step(1'b0, 1'b0, 32'h0);
        reset_mid();
        repeat (10) step(1'b0, 1'b0, 32'h0);

        // Random traffic: stalls, redirects (some near the top of memory), latencies.
        for (int i = 0; i < 2000; i++) begin
            logic        st, br;
            logic [31:0] tgt;
            if (i % 64 == 0) lat = $urandom_range(0, 3);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 19) == 0);
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, tgt[3:0]};
            step(st, br, tgt);
        end
        repeat (6) step(1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
